// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the MIPS MEM stage
// Purpose: default SRAM base address, MEM-stage FSM state encoding and the
//          MEM/WB pipeline-register field layout.
// Ports:   none (package).
package mips_pkg;

  localparam int BASE_ADDR_DEF = 1024;
  localparam int DATA_W        = 32;
  localparam int REG_AW        = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef struct packed {
    logic              wb_en;
    logic              mem_r_en;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] mem_data;
    logic [REG_AW-1:0] dest;
  } mem_wb_t;

endpackage

// File: rtl/mem_wb_reg.sv
// rtl/mem_wb_reg.sv - MEM/WB pipeline register with bubble load
// Purpose: holds the fields presented to the WB stage. A bubble load clears
//          only the two enables; data fields keep their previous values.
// Ports:   clk, rst      clock, synchronous active-high reset
//          i_bubble      load a bubble instead of i_d
//          i_d           next MEM/WB contents
//          o_q           current MEM/WB contents
module mem_wb_reg
  import mips_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    i_bubble,
  input  mem_wb_t i_d,
  output mem_wb_t o_q
);

  mem_wb_t r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_bubble) begin
      r_q.wb_en    <= 1'b0;
      r_q.mem_r_en <= 1'b0;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/mem_stage_sram_if.sv
// rtl/mem_stage_sram_if.sv - MIPS MEM stage with SRAM req/ack interface and MEM/WB register
// Purpose: performs loads/stores on a word SRAM, freezes upstream stages while
//          an access is outstanding, then hands the result to WB.
// Config:  MEM_ALIGN_CHECK_EN - when defined, misaligned ops are dropped as
//          bubbles and raise the sticky mem_misalign flag.
// Ports:   clk, rst                      clock, synchronous active-high reset
//          exe_*                         EXE/MEM register outputs
//          freeze                        stall for IF/ID/EXE
//          sram_req/we/addr/wdata        SRAM request side
//          sram_rdata, sram_ack          SRAM response (ack is a 1-cycle pulse)
//          wb_*                          MEM/WB register outputs
//          mem_misalign                  sticky misalignment flag
module mem_stage_sram_if
  import mips_pkg::*;
#(
  parameter int BASE_ADDR = BASE_ADDR_DEF,
  parameter int SRAM_AW   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               exe_wb_en,
  input  logic               exe_mem_r_en,
  input  logic               exe_mem_w_en,
  input  logic [31:0]        exe_alu_res,
  input  logic [31:0]        exe_st_val,
  input  logic [4:0]         exe_dest,
  output logic               freeze,
  output logic               sram_req,
  output logic               sram_we,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_wdata,
  input  logic [31:0]        sram_rdata,
  input  logic               sram_ack,
  output logic               wb_en,
  output logic               wb_mem_r_en,
  output logic [31:0]        wb_alu_res,
  output logic [31:0]        wb_mem_data,
  output logic [4:0]         wb_dest,
  output logic               mem_misalign
);

  state_t             r_state;
  state_t             w_next;
  logic               w_mem_op;
  logic               w_misalign;
  logic               w_go;
  logic               w_freeze;
  logic               w_req;
  logic               w_bubble;
  logic [31:0]        w_off;
  logic [SRAM_AW-1:0] w_addr;
  logic               w_unused_off;

  logic               r_we;
  logic [SRAM_AW-1:0] r_addr;
  logic [31:0]        r_wdata;
  logic [31:0]        r_rdata;
  logic               r_wb_en;
  logic               r_rd_en;
  logic [31:0]        r_alu_res;
  logic [4:0]         r_dest;

  mem_wb_t            w_d;
  mem_wb_t            w_q;

  assign w_mem_op     = exe_mem_r_en | exe_mem_w_en;
  assign w_off        = exe_alu_res - 32'(BASE_ADDR);
  // Upper bits wrap modulo the SRAM size; low bits select a byte in the word.
  assign w_addr       = w_off[SRAM_AW+1:2];
  assign w_unused_off = ^{w_off[31:SRAM_AW+2], w_off[1:0]};

`ifdef MEM_ALIGN_CHECK_EN
  logic r_misalign;

  assign w_misalign = w_mem_op & (exe_alu_res[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_misalign <= 1'b0;
    end else if (r_state == IDLE && w_misalign) begin
      r_misalign <= 1'b1;
    end
  end

  assign mem_misalign = r_misalign;
`else
  assign w_misalign   = 1'b0;
  assign mem_misalign = 1'b0;
`endif

  // A misaligned op never starts an access; it falls through as a bubble.
  assign w_go = w_mem_op & ~w_misalign;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_go) w_next = ACCESS;
      ACCESS:  if (sram_ack) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_freeze = 1'b0;
    w_req    = 1'b0;
    w_bubble = 1'b0;
    if (!rst) begin
      case (r_state)
        IDLE: begin
          w_freeze = w_go;
          w_bubble = w_go | w_misalign;
        end
        ACCESS: begin
          w_freeze = 1'b1;
          w_req    = 1'b1;
          w_bubble = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // The op stays on exe_* while frozen, but the result is latched at op
  // start so DONE does not depend on upstream holding its outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_wb_en   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_alu_res <= '0;
      r_dest    <= '0;
    end else begin
      if (r_state == IDLE && w_go) begin
        r_we      <= exe_mem_w_en;
        r_addr    <= w_addr;
        r_wdata   <= exe_st_val;
        r_wb_en   <= exe_wb_en;
        r_rd_en   <= exe_mem_r_en & ~exe_mem_w_en;
        r_alu_res <= exe_alu_res;
        r_dest    <= exe_dest;
      end
      if (r_state == ACCESS && sram_ack && !r_we) begin
        r_rdata <= sram_rdata;
      end
    end
  end

  always_comb begin
    if (r_state == DONE) begin
      w_d = '{wb_en: r_wb_en, mem_r_en: r_rd_en, alu_res: r_alu_res,
              mem_data: r_rdata, dest: r_dest};
    end else begin
      w_d = '{wb_en: exe_wb_en, mem_r_en: 1'b0, alu_res: exe_alu_res,
              mem_data: r_rdata, dest: exe_dest};
    end
  end

  mem_wb_reg u_mem_wb_reg (
    .clk      (clk),
    .rst      (rst),
    .i_bubble (w_bubble),
    .i_d      (w_d),
    .o_q      (w_q)
  );

  assign freeze      = w_freeze;
  assign sram_req    = w_req;
  assign sram_we     = r_we;
  assign sram_addr   = r_addr;
  assign sram_wdata  = r_wdata;
  assign wb_en       = w_q.wb_en;
  assign wb_mem_r_en = w_q.mem_r_en;
  assign wb_alu_res  = w_q.alu_res;
  assign wb_mem_data = w_q.mem_data;
  assign wb_dest     = w_q.dest;

endmodule
